// File: rtl/alu_display.sv
// Captures ALU results on `done`, converts the 6-bit magnitude to BCD with a
// sequential double-dabble engine and scans it onto a 4-digit common-anode display.
module alu_display #(
  parameter int REFRESH_DIV = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       done,
  input  logic [5:0] resul,
  input  logic       Signo,
  input  logic       C_out,
  output logic       busy,
  output logic       valid,
  output logic [3:0] an,
  output logic [6:0] seg
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_C     = 7'b1000110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    SHOW = 2'd2
  } state_t;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  function automatic logic [3:0] dd_adjust(input logic [3:0] n);
    return (n >= 4'd5) ? (n + 4'd3) : n;
  endfunction

  state_t     state_r, state_s;
  logic [5:0] bin_r;
  logic [3:0] tens_r, units_r;
  logic [2:0] iter_r;
  logic       sign_r, carry_r;
  logic [3:0] disp_tens_r, disp_units_r;
  logic       disp_sign_r, disp_carry_r;
  logic       valid_r;
  logic [CW-1:0] scan_r;
  logic [1:0] idx_r;
  logic [3:0] an_r;
  logic [6:0] seg_r;

  logic       capture_s, iterate_s, load_s;
  logic [3:0] tens_adj_s, units_adj_s;
  logic [3:0] disp_tens_s, disp_units_s;
  logic       disp_sign_s, disp_carry_s, valid_s;
  logic [1:0] idx_s;
  logic [3:0] an_s;
  logic [6:0] seg_s;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode and datapath strobes
  always_comb begin
    state_s   = state_r;
    capture_s = 1'b0;
    iterate_s = 1'b0;
    load_s    = 1'b0;
    case (state_r)
      IDLE, SHOW: begin
        if (done) begin
          capture_s = 1'b1;
          state_s   = CONV;
        end else begin
          state_s   = state_r;
        end
      end
      CONV: begin
        // Six shift iterations complete when the counter reads 6; this edge publishes.
        if (iter_r == 3'd6) begin
          load_s  = 1'b1;
          state_s = SHOW;
        end else begin
          iterate_s = 1'b1;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  assign tens_adj_s  = dd_adjust(tens_r);
  assign units_adj_s = dd_adjust(units_r);

  // Capture shadow registers and run the double-dabble iterations
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_r   <= 6'd0;
      tens_r  <= 4'd0;
      units_r <= 4'd0;
      iter_r  <= 3'd0;
      sign_r  <= 1'b0;
      carry_r <= 1'b0;
    end else if (capture_s) begin
      bin_r   <= resul;
      sign_r  <= Signo;
      carry_r <= C_out;
      tens_r  <= 4'd0;
      units_r <= 4'd0;
      iter_r  <= 3'd0;
    end else if (iterate_s) begin
      tens_r  <= {tens_adj_s[2:0], units_adj_s[3]};
      units_r <= {units_adj_s[2:0], bin_r[5]};
      bin_r   <= {bin_r[4:0], 1'b0};
      iter_r  <= iter_r + 3'd1;
    end
  end

  // Display holding registers and the sticky valid flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_tens_r  <= 4'd0;
      disp_units_r <= 4'd0;
      disp_sign_r  <= 1'b0;
      disp_carry_r <= 1'b0;
      valid_r      <= 1'b0;
    end else begin
      disp_tens_r  <= disp_tens_s;
      disp_units_r <= disp_units_s;
      disp_sign_r  <= disp_sign_s;
      disp_carry_r <= disp_carry_s;
      valid_r      <= valid_s;
    end
  end

  // Free-running digit scan counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_r <= '0;
      idx_r  <= 2'd0;
    end else if (scan_r == CW'(REFRESH_DIV - 1)) begin
      scan_r <= '0;
      idx_r  <= idx_s;
    end else begin
      scan_r <= scan_r + CW'(1);
      idx_r  <= idx_s;
    end
  end

  // Outputs are built from next-cycle values so an/seg/valid move on one edge
  always_comb begin
    disp_tens_s  = load_s ? tens_r  : disp_tens_r;
    disp_units_s = load_s ? units_r : disp_units_r;
    disp_sign_s  = load_s ? sign_r  : disp_sign_r;
    disp_carry_s = load_s ? carry_r : disp_carry_r;
    valid_s      = valid_r | load_s;
    if (scan_r == CW'(REFRESH_DIV - 1)) begin
      idx_s = idx_r + 2'd1;
    end else begin
      idx_s = idx_r;
    end
    an_s  = ~(4'b0001 << idx_s);
    seg_s = SEG_BLANK;
    case (idx_s)
      2'd0:    seg_s = seg_code(disp_units_s);
      2'd1:    seg_s = (disp_tens_s == 4'd0) ? SEG_BLANK : seg_code(disp_tens_s);
      2'd2:    seg_s = disp_carry_s ? SEG_C : SEG_BLANK;
      2'd3:    seg_s = disp_sign_s ? SEG_MINUS : SEG_BLANK;
      default: seg_s = SEG_BLANK;
    endcase
    if (!valid_s) begin
      seg_s = SEG_BLANK;
    end else begin
      seg_s = seg_s;
    end
  end

  // Registered digit enables and segments
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_r  <= 4'b1111;
      seg_r <= SEG_BLANK;
    end else begin
      an_r  <= an_s;
      seg_r <= seg_s;
    end
  end

  assign busy  = (state_r == CONV);
  assign valid = valid_r;
  assign an    = an_r;
  assign seg   = seg_r;

endmodule
